// File: rtl/axi4_ram_bridge.sv
// axi4_ram_bridge: AXI4 slave with one transaction in flight, turning FIXED/INCR
// bursts into single-word RAMHelper reads and masked writes (64-bit data path).
module axi4_ram_bridge #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter logic [63:0] MEM_BASE  = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_WORDS = 64'd201326592
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [7:0]        aw_len,
  input  logic [2:0]        aw_size,
  input  logic [1:0]        aw_burst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [63:0]       w_data,
  input  logic [7:0]        w_strb,
  input  logic              w_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [ID_W-1:0]   b_id,
  output logic [1:0]        b_resp,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [63:0]       r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              ram_en,
  output logic [63:0]       ram_rIdx,
  input  logic [63:0]       ram_rdata,
  output logic [63:0]       ram_wIdx,
  output logic [63:0]       ram_wdata,
  output logic [63:0]       ram_wmask,
  output logic              ram_wen
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WRESP} state_t;

  state_t          state_reg, state_next;
  logic            prio_wr_reg;   // 0: read wins a tie, 1: write wins a tie
  logic [ID_W-1:0] id_reg;
  logic [63:0]     idx_reg;
  logic [7:0]      len_reg;
  logic [7:0]      cnt_reg;
  logic            fixed_reg;
  logic            err_reg;
  logic [63:0]     r_data_reg;
  logic [1:0]      r_resp_reg;
  logic            r_last_reg;

  logic        grant_rd, grant_wr;
  logic        ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic [63:0] ar_idx, aw_idx, step_idx, load_idx;
  logic        rd_load, load_oor, wr_oor, last_beat;
  logic [63:0] strb_mask;
  logic        unused_ok;

  // Word index relative to the RAM base; the subtraction wraps in 64 bits so
  // addresses below the base land far out of range.
  assign ar_idx   = (64'(ar_addr) - MEM_BASE) >> 3;
  assign aw_idx   = (64'(aw_addr) - MEM_BASE) >> 3;
  assign step_idx = fixed_reg ? idx_reg : idx_reg + 64'd1;

  // Arbitration is only meaningful in IDLE; a tie goes to the priority side.
  assign grant_rd = (state_reg == S_IDLE) && ar_valid && (!aw_valid || !prio_wr_reg);
  assign grant_wr = (state_reg == S_IDLE) && aw_valid && !grant_rd;

  // Handshakes derived from state so the output decode never feeds back on itself.
  assign ar_hs = grant_rd;
  assign aw_hs = grant_wr;
  assign r_hs  = (state_reg == S_RD) && r_ready;
  assign w_hs  = (state_reg == S_WR) && w_valid;
  assign b_hs  = (state_reg == S_WRESP) && b_ready;

  // A RAM read is issued on the AR handshake and on every non-final R handshake.
  assign rd_load   = ar_hs || (r_hs && !r_last_reg);
  assign load_idx  = ar_hs ? ar_idx : step_idx;
  assign load_oor  = (load_idx >= MEM_WORDS);
  assign wr_oor    = (idx_reg >= MEM_WORDS);
  assign last_beat = (cnt_reg == len_reg);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_strb
      assign strb_mask[gi*8 +: 8] = {8{w_strb[gi]}};
    end
  endgenerate

  // Transfer size is fixed at 8 bytes, so the size fields carry no information.
  assign unused_ok = ^{aw_size, ar_size};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: the beat counter, not w_last, ends a write burst.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (grant_rd) state_next = S_RD;
               else if (grant_wr) state_next = S_WR;
      S_RD:    if (r_hs && r_last_reg) state_next = S_IDLE;
      S_WR:    if (w_hs && last_beat) state_next = S_WRESP;
      S_WRESP: if (b_hs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: channel handshakes and RAMHelper strobes (index buses idle at 0).
  always_comb begin
    ar_ready  = grant_rd;
    aw_ready  = grant_wr;
    r_valid   = (state_reg == S_RD);
    w_ready   = (state_reg == S_WR);
    b_valid   = (state_reg == S_WRESP);
    ram_en    = (rd_load && !load_oor) || (w_hs && !wr_oor);
    ram_rIdx  = (rd_load && !load_oor) ? load_idx : 64'd0;
    ram_wen   = w_hs && !wr_oor;
    ram_wIdx  = 64'd0;
    ram_wdata = 64'd0;
    ram_wmask = 64'd0;
    if (w_hs && !wr_oor) begin
      ram_wIdx  = idx_reg;
      ram_wdata = w_data;
      ram_wmask = strb_mask;
    end
  end

  assign r_id   = id_reg;
  assign b_id   = id_reg;
  assign r_data = r_data_reg;
  assign r_resp = r_resp_reg;
  assign r_last = r_last_reg;
  assign b_resp = err_reg ? RESP_SLVERR : RESP_OKAY;

  // Burst context: capture on address handshake, advance index/count per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_wr_reg <= 1'b0;
      id_reg      <= '0;
      idx_reg     <= 64'd0;
      len_reg     <= 8'd0;
      cnt_reg     <= 8'd0;
      fixed_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      if ((state_reg == S_IDLE) && ar_valid && aw_valid)
        prio_wr_reg <= !prio_wr_reg;
      if (ar_hs) begin
        id_reg    <= ar_id;
        idx_reg   <= ar_idx;
        len_reg   <= ar_len;
        cnt_reg   <= 8'd0;
        fixed_reg <= (ar_burst == BURST_FIXED);
      end else if (aw_hs) begin
        id_reg    <= aw_id;
        idx_reg   <= aw_idx;
        len_reg   <= aw_len;
        cnt_reg   <= 8'd0;
        fixed_reg <= (aw_burst == BURST_FIXED);
      end else if ((r_hs && !r_last_reg) || w_hs) begin
        idx_reg <= step_idx;
        cnt_reg <= cnt_reg + 8'd1;
      end
      if (aw_hs)
        err_reg <= 1'b0;
      else if (w_hs)
        err_reg <= err_reg | wr_oor | (w_last != last_beat);
      else if (b_hs)
        err_reg <= 1'b0;
    end
  end

  // Read beat register: holds the presented beat until the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_reg <= 64'd0;
      r_resp_reg <= RESP_OKAY;
      r_last_reg <= 1'b0;
    end else if (rd_load) begin
      r_data_reg <= load_oor ? 64'd0 : ram_rdata;
      r_resp_reg <= load_oor ? RESP_SLVERR : RESP_OKAY;
      r_last_reg <= ar_hs ? (ar_len == 8'd0) : ((cnt_reg + 8'd1) == len_reg);
    end
  end

endmodule

// File: tb/tb_axi4_ram_bridge.sv
// tb_axi4_ram_bridge: scoreboard bench; a small word RAM stands in for RAMHelper.
module tb_axi4_ram_bridge;

  localparam logic [63:0] MEM_BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MEM_WORDS = 64'd201326592;

  logic        clk, rst_n;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last, ram_en, ram_wen;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [63:0] w_data, r_data, ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;

  axi4_ram_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last),
    .ram_en(ram_en), .ram_rIdx(ram_rIdx), .ram_rdata(ram_rdata), .ram_wIdx(ram_wIdx),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
  typedef struct { logic [63:0] idx; logic [63:0] data; logic [63:0] mask; } wexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rexp_t       rq[$];
  wexp_t       wq[$];
  bexp_t       bq[$];
  logic [63:0] riq[$];
  logic [63:0] exp_mem [logic [63:0]];

  int n_cmp = 0;
  int n_err = 0;
  int r_seen = 0;
  int b_seen = 0;
  bit prio_wr_model = 0;

  logic [63:0] cur_widx;
  logic [7:0]  cur_wlen;
  logic [1:0]  cur_wburst;
  logic [3:0]  cur_wid;
  bit          cur_werr;

  // Stand-in RAM: 16 words addressed by the low index nibble, preset contents.
  logic [63:0] env_mem [16];
  bit   [15:0] env_written;

  function automatic logic [63:0] init_word(input logic [63:0] ix);
    return {32'hC0DE_5A5A, ix[31:0]};
  endfunction

  function automatic logic [63:0] env_rd(input logic [63:0] ix);
    return env_written[ix[3:0]] ? env_mem[ix[3:0]] : init_word(ix);
  endfunction

  function automatic logic [63:0] exp_rd(input logic [63:0] ix);
    if (exp_mem.exists(ix)) return exp_mem[ix];
    return init_word(ix);
  endfunction

  assign ram_rdata = env_rd(ram_rIdx);

  always @(posedge clk) begin
    if (ram_wen) begin
      env_mem[ram_wIdx[3:0]]     <= (env_rd(ram_wIdx) & ~ram_wmask) | (ram_wdata & ram_wmask);
      env_written[ram_wIdx[3:0]] <= 1'b1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check_val("one_ready", 64'(ar_ready & aw_ready), 64'd0);
      check_val("en_needs_hs", 64'(ram_en & ~((ar_valid & ar_ready) | (r_valid & r_ready) | (w_valid & w_ready))), 64'd0);
      if (!ram_en) begin
        check_val("ridx_idle", ram_rIdx, 64'd0);
        check_val("widx_idle", ram_wIdx, 64'd0);
      end
      if (r_valid) begin
        if (rq.size() == 0) check_val("r_unexpected", 64'(rq.size()), 64'd1);
        else begin
          check_val("r_data", r_data, rq[0].data);
          check_val("r_resp", 64'(r_resp), 64'(rq[0].resp));
          check_val("r_last", 64'(r_last), 64'(rq[0].last));
          check_val("r_id", 64'(r_id), 64'(rq[0].id));
          if (r_ready) begin
            void'(rq.pop_front());
            r_seen++;
            $display("R  beat id=%0h data=%h resp=%0d last=%0d", r_id, r_data, r_resp, r_last);
          end
        end
      end
      if (ram_en && !ram_wen) begin
        if (riq.size() == 0) check_val("ram_rd_unexpected", 64'(riq.size()), 64'd1);
        else check_val("ram_rIdx", ram_rIdx, riq.pop_front());
      end
      if (ram_wen) begin
        if (wq.size() == 0) check_val("ram_wr_unexpected", 64'(wq.size()), 64'd1);
        else begin
          check_val("ram_wIdx", ram_wIdx, wq[0].idx);
          check_val("ram_wdata", ram_wdata, wq[0].data);
          check_val("ram_wmask", ram_wmask, wq[0].mask);
          void'(wq.pop_front());
          $display("W  ram idx=%0h data=%h mask=%h", ram_wIdx, ram_wdata, ram_wmask);
        end
      end
      if (b_valid && b_ready) begin
        if (bq.size() == 0) check_val("b_unexpected", 64'(bq.size()), 64'd1);
        else begin
          check_val("b_id", 64'(b_id), 64'(bq[0].id));
          check_val("b_resp", 64'(b_resp), 64'(bq[0].resp));
          void'(bq.pop_front());
          b_seen++;
          $display("B  resp id=%0h resp=%0d", b_id, b_resp);
        end
      end
    end
  end

  task automatic prep_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [3:0] id);
    logic [63:0] idx0, ix;
    rexp_t e;
    idx0 = (64'(addr) - MEM_BASE) >> 3;
    for (int b = 0; b <= int'(len); b++) begin
      ix = (burst == 2'b00) ? idx0 : idx0 + 64'(b);
      e.id = id;
      e.last = (b == int'(len));
      if (ix < MEM_WORDS) begin
        e.data = exp_rd(ix); e.resp = 2'b00;
        riq.push_back(ix);
      end else begin
        e.data = 64'd0; e.resp = 2'b10;
      end
      rq.push_back(e);
    end
    ar_addr = addr; ar_len = len; ar_burst = burst; ar_id = id; ar_size = 3'd3;
    ar_valid = 1'b1;
  endtask

  task automatic prep_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [3:0] id);
    cur_widx = (64'(addr) - MEM_BASE) >> 3;
    cur_wlen = len; cur_wburst = burst; cur_wid = id; cur_werr = 0;
    aw_addr = addr; aw_len = len; aw_burst = burst; aw_id = id; aw_size = 3'd3;
    aw_valid = 1'b1;
  endtask

  task automatic wait_ar();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = ar_ready; end
    check_val("ar_handshake", 64'(seen), 64'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wait_aw();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = aw_ready; end
    check_val("aw_handshake", 64'(seen), 64'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  // One W beat of the current write burst; expectations are queued before driving.
  task automatic drive_beat(input int b, input logic [63:0] data, input logic [7:0] strb, input logic lastv);
    logic [63:0] ix, mask;
    bit seen;
    for (int k = 0; k < 8; k++) mask[k*8 +: 8] = strb[k] ? 8'hFF : 8'h00;
    ix = (cur_wburst == 2'b00) ? cur_widx : cur_widx + 64'(b);
    if (ix < MEM_WORDS) begin
      wq.push_back('{ix, data, mask});
      exp_mem[ix] = (exp_rd(ix) & ~mask) | (data & mask);
    end else cur_werr = 1;
    if (lastv != (b == int'(cur_wlen))) cur_werr = 1;
    w_valid = 1'b1; w_data = data; w_strb = strb; w_last = lastv;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = w_ready; end
    check_val("w_handshake", 64'(seen), 64'd1);
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] seed, input logic [7:0] strb, input int bad_last);
    for (int b = 0; b <= int'(cur_wlen); b++)
      drive_beat(b, seed + 64'(b), strb, (b == int'(cur_wlen)) ^ (b == bad_last));
    bq.push_back('{cur_wid, cur_werr ? 2'b10 : 2'b00});
  endtask

  task automatic recv_r(input int n, input bit stall);
    int target, guard;
    target = r_seen + n; guard = 0;
    r_ready = !stall;
    while (r_seen < target && guard < 100) begin
      @(posedge clk); #1;
      guard++;
      if (stall) r_ready = !r_ready;
    end
    r_ready = 1'b0;
    check_val("r_beats", 64'(r_seen), 64'(target));
  endtask

  task automatic recv_b();
    int target, guard;
    target = b_seen + 1; guard = 0;
    b_ready = 1'b1;
    while (b_seen < target && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    b_ready = 1'b0;
    check_val("b_count", 64'(b_seen), 64'(target));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [63:0] seed, input logic [7:0] strb, input int bad_last);
    prep_aw(addr, len, burst, id);
    wait_aw();
    send_w(seed, strb, bad_last);
    recv_b();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input bit stall);
    prep_ar(addr, len, burst, id);
    wait_ar();
    recv_r(int'(len) + 1, stall);
  endtask

  // Both address channels raised together; the bench's own priority bit picks the winner.
  task automatic contest(input logic [31:0] waddr, input logic [3:0] rid, input logic [3:0] wid, input logic [63:0] seed);
    bit exp_rd_first;
    exp_rd_first = !prio_wr_model;
    prep_ar(32'h8000_0040, 8'd1, 2'b01, rid);
    prep_aw(waddr, 8'd0, 2'b01, wid);
    #1;
    check_val("arb_ar_ready", 64'(ar_ready), 64'(exp_rd_first));
    check_val("arb_aw_ready", 64'(aw_ready), 64'(!exp_rd_first));
    $display("ARB winner=%s", ar_ready ? "read" : "write");
    prio_wr_model = !prio_wr_model;
    if (exp_rd_first) begin
      wait_ar(); recv_r(2, 1'b0);
      wait_aw(); send_w(seed, 8'hFF, -1); recv_b();
    end else begin
      wait_aw(); send_w(seed, 8'hFF, -1); recv_b();
      wait_ar(); recv_r(2, 1'b0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 3'd3; aw_burst = 2'b01;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 3'd3; ar_burst = 2'b01;
    r_ready = 0;
    #2;
    check_val("rst_ar_ready", 64'(ar_ready), 64'd0);
    check_val("rst_aw_ready", 64'(aw_ready), 64'd0);
    check_val("rst_w_ready", 64'(w_ready), 64'd0);
    check_val("rst_r_valid", 64'(r_valid), 64'd0);
    check_val("rst_b_valid", 64'(b_valid), 64'd0);
    check_val("rst_ram_en", 64'(ram_en), 64'd0);
    check_val("rst_ram_wen", 64'(ram_wen), 64'd0);
    check_val("rst_r_data", r_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Arbitration from reset: read, write, read.
    contest(32'h8000_0050, 4'h1, 4'h2, 64'h1111_2222_3333_0000);
    contest(32'h8000_0058, 4'h3, 4'h4, 64'h4444_5555_6666_0000);
    contest(32'h8000_0070, 4'h5, 4'h6, 64'h7777_8888_9999_0000);

    // Single-beat full-strobe write, then a stalled 4-beat INCR read.
    do_write(32'h8000_0010, 8'd0, 2'b01, 4'hA, 64'hDEAD_BEEF_0123_4567, 8'hFF, -1);
    do_read(32'h8000_0010, 8'd3, 2'b01, 4'h5, 1'b1);

    // Partial strobe keeps the upper bytes.
    do_write(32'h8000_0010, 8'd0, 2'b01, 4'hB, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, -1);
    do_read(32'h8000_0010, 8'd0, 2'b01, 4'hC, 1'b0);

    // FIXED burst repeats one index.
    do_read(32'h8000_0018, 8'd2, 2'b00, 4'h9, 1'b0);

    // Top of RAM: second beat falls out of range.
    do_read(32'hDFFF_FFF8, 8'd1, 2'b01, 4'hD, 1'b0);
    do_write(32'hDFFF_FFF8, 8'd1, 2'b01, 4'hE, 64'h0BAD_0000_0000_0100, 8'hFF, -1);
    do_read(32'hDFFF_FFF8, 8'd0, 2'b01, 4'hD, 1'b0);

    // Address below the base wraps to a huge index.
    do_read(32'h0000_0000, 8'd0, 2'b01, 4'h3, 1'b0);

    // Early w_last flags an error but the burst still runs to its length.
    do_write(32'h8000_0020, 8'd1, 2'b01, 4'h7, 64'h5EED_0000_0000_0000, 8'hFF, 0);
    do_read(32'h8000_0020, 8'd1, 2'b01, 4'h7, 1'b0);

    // Reset during the second beat of a 4-beat write aborts it.
    prep_aw(32'h8000_0060, 8'd3, 2'b01, 4'h6);
    wait_aw();
    drive_beat(0, 64'hABCD_0000_0000_0001, 8'hFF, 1'b0);
    w_valid = 1'b1; w_data = 64'hABCD_0000_0000_0002; w_strb = 8'hFF; w_last = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_w_ready", 64'(w_ready), 64'd0);
    check_val("mid_rst_aw_ready", 64'(aw_ready), 64'd0);
    check_val("mid_rst_b_valid", 64'(b_valid), 64'd0);
    check_val("mid_rst_r_valid", 64'(r_valid), 64'd0);
    check_val("mid_rst_ram_wen", 64'(ram_wen), 64'd0);
    w_valid = 1'b0;
    prio_wr_model = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("no_b_after_rst", 64'(b_valid), 64'd0);
    end
    @(posedge clk); #1;
    b_ready = 1'b0;
    do_read(32'h8000_0060, 8'd1, 2'b01, 4'h8, 1'b0);

    repeat (3) @(posedge clk);
    check_val("rq_left", 64'(rq.size()), 64'd0);
    check_val("wq_left", 64'(wq.size()), 64'd0);
    check_val("bq_left", 64'(bq.size()), 64'd0);
    check_val("riq_left", 64'(riq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
